// File: rtl/xuart_pkg.sv
// Shared definitions for the xuart transmitter: register offsets, STATUS/CTRL
// bit positions and the serialiser state encoding.
package xuart_pkg;

  localparam int XUART_TXDATA = 0;
  localparam int XUART_STATUS = 1;
  localparam int XUART_DIV    = 2;
  localparam int XUART_CTRL   = 3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/xuart_if.sv
// Parallel-bus slot between the ext address decoder and the UART register file.
interface xuart_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, we, addr, data_in, input data_out);
  modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xuart_fifo.sv
// Synchronous TX FIFO with a combinational head; a push while full is accepted
// only when a pop frees a slot on the same edge.
module xuart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/xuart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, per-frame baud counter and
// serialiser FSM. Define XUART_IRQ_EN to add the irq output and CTRL.irq_en.
module xuart_tx
  import xuart_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd867
) (
  input  logic    clk,
  input  logic    rst,
  xuart_if.slave  bus,
`ifdef XUART_IRQ_EN
  output logic    irq,
`endif
  output logic    txd
);
  logic        wr_en, rd_en, push, pop, load;
  logic        fifo_full, fifo_empty, busy;
  logic [7:0]  fifo_dout;
  logic [15:0] div_q;
  logic        tx_en_q, ovf_q, irq_en;
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] cnt_q, cnt_d, bdiv_q, bdiv_d;
  logic [2:0]  idx_q, idx_d;
  logic        txd_q, txd_d;
  logic [DATA_W-1:0] rdata;
  logic        unused_hi;

  assign wr_en     = bus.sel & bus.we;
  assign rd_en     = bus.sel & ~bus.we;
  assign push      = wr_en && (bus.addr == ADDR_W'(XUART_TXDATA));
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;
  assign unused_hi = ^bus.data_in[DATA_W-1:16];

  xuart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_RST;
      tx_en_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (wr_en) begin
      case (bus.addr)
        ADDR_W'(XUART_TXDATA): if (fifo_full && !pop) ovf_q <= 1'b1;
        ADDR_W'(XUART_STATUS): ovf_q <= 1'b0;
        ADDR_W'(XUART_DIV):    div_q <= bus.data_in[15:0];
        default:               tx_en_q <= bus.data_in[CTRL_TXEN];
      endcase
    end
  end

`ifdef XUART_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && bus.addr == ADDR_W'(XUART_CTRL)) irq_en_q <= bus.data_in[CTRL_IRQEN];
      // Fires once the line has fully drained, or on a dropped byte.
      irq_q <= irq_en_q & ((fifo_empty & (state_q == S_IDLE)) | ovf_q);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (bus.addr)
        ADDR_W'(XUART_STATUS): rdata[3:0]  = {ovf_q, fifo_empty, fifo_full, busy};
        ADDR_W'(XUART_DIV):    rdata[15:0] = div_q;
        ADDR_W'(XUART_CTRL):   rdata[1:0]  = {irq_en, tx_en_q};
        default:               rdata = '0;
      endcase
    end
  end
  assign bus.data_out = rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bdiv_q  <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bdiv_q  <= bdiv_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bdiv_d  = bdiv_q;
    idx_d   = idx_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:  load = tx_en_q & ~fifo_empty;
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = bdiv_q;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = bdiv_q;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else cnt_d = cnt_q - 16'd1;
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          load    = tx_en_q & ~fifo_empty;
        end else cnt_d = cnt_q - 16'd1;
      end
    endcase
    // DIV is sampled only here, so mid-frame DIV writes wait for the next frame.
    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      shift_d = fifo_dout;
      cnt_d   = div_q;
      bdiv_d  = div_q;
      idx_d   = '0;
    end
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;
endmodule

// File: tb/tb_xuart_tx.sv
// Directed/randomised bench for xuart_tx; expected line levels come from the
// frame arithmetic and a queue model of the TX FIFO.
module tb_xuart_tx;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
`ifdef XUART_IRQ_EN
  logic irq;
`endif

  xuart_if #(.DATA_W(32), .ADDR_W(2)) bus ();

  xuart_tx #(.DATA_W(32), .ADDR_W(2), .FIFO_DEPTH(FIFO_DEPTH), .DIV_RST(16'd867)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
`ifdef XUART_IRQ_EN
    .irq (irq),
`endif
    .txd (txd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic       ovf_m;

  initial begin
    #300000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0; bus.data_in = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    d = bus.data_out;
    bus.sel = 1'b0;
    #1;
    chk(tag, d, exp);
  endtask

  // Model push: a full queue drops the byte and raises the sticky overflow.
  task automatic push(input logic [7:0] b);
    wr(2'd0, {24'b0, b});
    if (q.size() == FIFO_DEPTH) ovf_m = 1'b1;
    else q.push_back(b);
  endtask

  function automatic logic [31:0] st_exp(input bit active);
    return {28'b0, ovf_m, (q.size() == 0), (q.size() == FIFO_DEPTH), (active || q.size() != 0)};
  endfunction

  // Frame cycle c of an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_txd(input logic [7:0] b, input int div, input int c);
    int bitn;
    bitn = c / (div + 1);
    if (bitn == 0) return 1'b0;
    if (bitn >= 9) return 1'b1;
    return b[bitn-1];
  endfunction

  task automatic frame(input logic [7:0] b, input int div, input int from, input int to, input string tag);
    for (int c = from; c < to; c++) begin
      chk($sformatf("%s_%02h_c%0d", tag, b, c), 32'(txd), 32'(exp_txd(b, div, c)));
      step();
    end
  endtask

  initial begin
    logic [7:0] a, b, c;
    int div;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
    ovf_m = 1'b0;

    rst = 1'b1;
    repeat (3) begin
      step();
      chk("rst_txd", 32'(txd), 32'd1);
    end
    rst = 1'b0;
    step();
    chk_reg("rst_status", 2'd1, 32'h4);
    chk_reg("rst_div", 2'd2, 32'd867);
    chk_reg("rst_ctrl", 2'd3, 32'd0);
    chk_reg("rst_txdata", 2'd0, 32'd0);
    chk("idle_txd", 32'(txd), 32'd1);

    // Single 0x55 frame at DIV=3.
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd1);
    push(8'h55);
    chk("push_idle_txd", 32'(txd), 32'd1);
    step();
    b = q.pop_front();
    chk_reg("busy_start", 2'd1, st_exp(1));
    frame(b, 3, 0, 39, "f55");
    chk_reg("busy_stop", 2'd1, st_exp(1));
    frame(b, 3, 39, 40, "f55");
    chk_reg("busy_done", 2'd1, st_exp(0));

    // Random bytes at random short divisors.
    for (int i = 0; i < 3; i++) begin
      div = int'($urandom_range(0, 3));
      wr(2'd2, 32'(div));
      push(8'($urandom));
      step();
      b = q.pop_front();
      frame(b, div, 0, 10 * (div + 1), "frnd");
    end
    chk_reg("rnd_done", 2'd1, st_exp(0));

    // Fill, overflow, clear, then drain back-to-back at DIV=0.
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd0);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    chk_reg("full", 2'd1, st_exp(0));
    push(8'($urandom));
    chk_reg("overflow", 2'd1, st_exp(0));
    wr(2'd1, 32'd0);
    ovf_m = 1'b0;
    chk_reg("ovf_clr", 2'd1, st_exp(0));
    wr(2'd3, 32'd1);
    step();
    for (int i = 0; i < 4; i++) frame(q.pop_front(), 0, 0, 10, "fb2b");
    chk_reg("b2b_done", 2'd1, st_exp(0));

    // Push while full on the very edge that pops the head.
    wr(2'd3, 32'd0);
    for (int i = 0; i < 4; i++) push(8'($urandom));
    wr(2'd3, 32'd1);
    b = q.pop_front();
    push(8'hA5);
    chk_reg("push_on_pop", 2'd1, st_exp(1));
    frame(b, 0, 0, 10, "fpop");
    for (int i = 0; i < 4; i++) frame(q.pop_front(), 0, 0, 10, "fpop");
    chk_reg("pop_done", 2'd1, st_exp(0));

    // DIV change mid-frame and tx_en cleared mid-frame.
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd3);
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    wr(2'd3, 32'd1);
    step();
    a = q.pop_front();
    frame(a, 3, 0, 21, "fdiv");
    wr(2'd2, 32'd1);
    frame(a, 3, 22, 40, "fdiv");
    b = q.pop_front();
    frame(b, 1, 0, 9, "fnew");
    wr(2'd3, 32'd0);
    frame(b, 1, 10, 20, "fnew");
    repeat (3) begin
      chk("hold_txd", 32'(txd), 32'd1);
      step();
    end
    chk_reg("held_status", 2'd1, st_exp(0));
    chk_reg("held_div", 2'd2, 32'd1);

    // Reset in the middle of a frame with another byte queued.
    wr(2'd3, 32'd1);
    step();
    c = q.pop_front();
    frame(c, 1, 0, 5, "frst");
    push(8'($urandom));
    frame(c, 1, 6, 7, "frst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    chk("rst_mid_txd", 32'(txd), 32'd1);
    chk_reg("rst_mid_status", 2'd1, 32'h4);
    chk_reg("rst_mid_ctrl", 2'd3, 32'd0);
    chk_reg("rst_mid_div", 2'd2, 32'd867);
    repeat (2) begin
      step();
      chk("post_rst_txd", 32'(txd), 32'd1);
    end

`ifdef XUART_IRQ_EN
    wr(2'd2, 32'd0);
    chk("irq_off", 32'(irq), 32'd0);
    wr(2'd3, 32'd3);
    chk_reg("irq_ctrl", 2'd3, 32'd3);
    step();
    chk("irq_idle", 32'(irq), 32'd1);
    push(8'h3C);
    step();
    chk("irq_push_drop", 32'(irq), 32'd0);
    b = q.pop_front();
    frame(b, 0, 0, 5, "firq");
    chk("irq_mid", 32'(irq), 32'd0);
    frame(b, 0, 5, 10, "firq");
    step();
    chk("irq_drained", 32'(irq), 32'd1);
    push(8'hC3);
    step();
    b = q.pop_front();
    frame(b, 0, 0, 4, "firq2");
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk("irq_rst", 32'(irq), 32'd0);
    chk("irq_rst_txd", 32'(txd), 32'd1);
    chk_reg("irq_rst_status", 2'd1, 32'h4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
